// File: rtl/taadda_io_pkg.sv
// Shared definitions for the CPU level-I/O buffers (output side now, input side later).
package taadda_io_pkg;

    localparam int IO_BYTE_W             = 8;
    localparam int IO_FIFO_DEPTH_DEFAULT = 16;

    // Read/write pointer width for a power-of-two FIFO depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy width: one extra bit so the value DEPTH itself is representable.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/arch_output_buffer_if.sv
// Bundle of the capture side (core output port) and drain side (consumer handshake).
// Optional statistics outputs exist only when ARCH_OUTPUT_BUFFER_STATS_EN is defined.
interface arch_output_buffer_if
    import taadda_io_pkg::*;
#(
    parameter int DEPTH      = IO_FIFO_DEPTH_DEFAULT,
    parameter int DATA_WIDTH = IO_BYTE_W
) ();

    logic                      in_en;
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_data;
    logic [level_w(DEPTH)-1:0] level;
    logic                      overflow;
    logic                      ovf_clr;
`ifdef ARCH_OUTPUT_BUFFER_STATS_EN
    logic [15:0]               tx_count;
    logic [7:0]                drop_count;
`endif

    // Core and consumer side: drives bytes in, takes bytes out.
    modport master (
        output in_en, in_data, out_ready, ovf_clr,
        input  out_valid, out_data, level, overflow
`ifdef ARCH_OUTPUT_BUFFER_STATS_EN
        , input tx_count, drop_count
`endif
    );

    // Buffer side.
    modport slave (
        input  in_en, in_data, out_ready, ovf_clr,
        output out_valid, out_data, level, overflow
`ifdef ARCH_OUTPUT_BUFFER_STATS_EN
        , output tx_count, drop_count
`endif
    );

endinterface

// File: rtl/arch_fifo_ctrl.sv
// FIFO bookkeeping: pointers, occupancy and push/pop/drop qualification.
// A push into a full FIFO is accepted only if a pop frees a slot in the same cycle.
module arch_fifo_ctrl
    import taadda_io_pkg::*;
#(
    parameter int DEPTH = IO_FIFO_DEPTH_DEFAULT,
    localparam int PW   = ptr_w(DEPTH),
    localparam int LW   = level_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_en,
    input  logic          out_ready,
    output logic          push,
    output logic          pop,
    output logic          drop,
    output logic          empty,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [LW-1:0] level
);

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic full;

    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);
    assign pop   = ~empty & out_ready;
    assign push  = in_en & (~full | pop);
    assign drop  = in_en & full & ~pop;

    // Advance pointers modulo DEPTH and track occupancy explicitly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // NOTE: state registers use <= so every update sees pre-edge values, regardless of statement order.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/arch_output_buffer.sv
// Output byte buffer for the CPU level-output port: captures bytes into a show-ahead
// FIFO, drains them over valid/ready, and flags drops with a sticky overflow bit.
// Define ARCH_OUTPUT_BUFFER_STATS_EN to add tx_count / drop_count outputs.
module arch_output_buffer
    import taadda_io_pkg::*;
#(
    parameter int DEPTH      = IO_FIFO_DEPTH_DEFAULT,
    parameter int DATA_WIDTH = IO_BYTE_W,
    localparam int PW        = ptr_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    arch_output_buffer_if.slave  bus
);

    logic          push;
    logic          pop;
    logic          drop;
    logic          empty;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    arch_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_en     (bus.in_en),
        .out_ready (bus.out_ready),
        .push      (push),
        .pop       (pop),
        .drop      (drop),
        .empty     (empty),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .level     (bus.level)
    );

    // Write accepted bytes into storage at the tail.
    // NOTE: storage has no reset; contents are don't-care until written, and this keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    // Show-ahead head byte, forced to zero while empty.
    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr];

    // Sticky overflow: a drop sets it and wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              bus.overflow <= 1'b0;
        else if (drop)         bus.overflow <= 1'b1;
        else if (bus.ovf_clr)  bus.overflow <= 1'b0;
    end

`ifdef ARCH_OUTPUT_BUFFER_STATS_EN
    // Popped-byte counter (wrapping) and dropped-byte counter (saturating, cleared with overflow).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.tx_count   <= '0;
            bus.drop_count <= '0;
        end else begin
            if (pop) bus.tx_count <= bus.tx_count + 16'd1;
            if (drop) begin
                if (bus.ovf_clr)                bus.drop_count <= 8'd1;
                else if (bus.drop_count != '1)  bus.drop_count <= bus.drop_count + 8'd1;
            end else if (bus.ovf_clr) begin
                bus.drop_count <= '0;
            end
        end
    end
`else
    logic unused_pop;
    assign unused_pop = pop;
`endif

endmodule

// File: tb/tb_arch_output_buffer.sv
// Self-checking bench for arch_output_buffer: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the buffer.
module tb_arch_output_buffer;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    arch_output_buffer_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    arch_output_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [DW-1:0] q[$];
    logic          m_ovf   = 1'b0;
    int unsigned   m_tx    = 0;
    int unsigned   m_drops = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
        check({tag, "_data"},  32'(bus.out_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check({tag, "_level"}, 32'(bus.level),     32'(q.size()));
        check({tag, "_ovf"},   32'(bus.overflow),  32'(m_ovf));
`ifdef ARCH_OUTPUT_BUFFER_STATS_EN
        check({tag, "_tx"},    32'(bus.tx_count),   32'(m_tx));
        check({tag, "_drops"}, 32'(bus.drop_count), 32'(m_drops));
`endif
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic step(input string tag, input logic en, input logic [DW-1:0] data,
                        input logic rdy, input logic clr);
        bit do_pop, do_push, do_drop;
        bus.in_en     = en;
        bus.in_data   = data;
        bus.out_ready = rdy;
        bus.ovf_clr   = clr;
        do_pop  = rdy && (q.size() > 0);
        do_push = en && ((q.size() < DEPTH) || do_pop);
        do_drop = en && !do_push;
        if (do_pop) begin
            void'(q.pop_front());
            m_tx = (m_tx + 1) % 65536;
        end
        if (do_push) q.push_back(data);
        if (do_drop)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (do_drop)  m_drops = clr ? 1 : ((m_drops == 255) ? 255 : m_drops + 1);
        else if (clr) m_drops = 0;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst           = 1'b0;
        bus.in_en     = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: three captures with consumer stalled.
        step("t1", 1'b1, 8'h11, 1'b0, 1'b0);
        step("t1", 1'b1, 8'h22, 1'b0, 1'b0);
        step("t1", 1'b1, 8'h33, 1'b0, 1'b0);
        check("t1_level_const", 32'(bus.level), 32'd3);
        check("t1_data_const",  32'(bus.out_data), 32'h11);

        // 2: drain them in order.
        check("t2_head0", 32'(bus.out_data), 32'h11);
        step("t2", 1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_head1", 32'(bus.out_data), 32'h22);
        step("t2", 1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_head2", 32'(bus.out_data), 32'h33);
        step("t2", 1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_empty_valid", 32'(bus.out_valid), 32'd0);
        step("t2_ready_empty", 1'b0, 8'h00, 1'b1, 1'b0);

        // 3: fill, overflow with 0xAA, drain without 0xAA.
        for (int i = 0; i < DEPTH; i++) step("t3_fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("t3_drop", 1'b1, 8'hAA, 1'b0, 1'b0);
        check("t3_level_const", 32'(bus.level), 32'd16);
        check("t3_ovf_const",   32'(bus.overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check("t3_drain_const", 32'(bus.out_data), 32'(i));
            step("t3_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("t3_drained", 32'(bus.out_valid), 32'd0);
        step("t3_clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // 4: full FIFO with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) step("t4_fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("t4_both", 1'b1, 8'hBB, 1'b1, 1'b0);
        check("t4_level_const", 32'(bus.level), 32'd16);
        check("t4_head_const",  32'(bus.out_data), 32'h01);
        check("t4_ovf_const",   32'(bus.overflow), 32'd0);
        for (int i = 1; i < DEPTH; i++) step("t4_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_tail_const", 32'(bus.out_data), 32'hBB);
        step("t4_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // 5: drop with clear (set wins), then clear alone.
        for (int i = 0; i < DEPTH; i++) step("t5_fill", 1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
        step("t5_drop_clr", 1'b1, 8'hCC, 1'b0, 1'b1);
        check("t5_ovf_set", 32'(bus.overflow), 32'd1);
        step("t5_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_ovf_clr", 32'(bus.overflow), 32'd0);

        // 6: asynchronous reset mid-drain with 5 queued.
        for (int i = 0; i < DEPTH - 5; i++) step("t6_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_queued", 32'(bus.level), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0; m_tx = 0; m_drops = 0;
        check_all("t6_async");
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_all("t6_held");
        rst = 1'b1;
        step("t6_push", 1'b1, 8'h5A, 1'b0, 1'b0);
        check("t6_data_const", 32'(bus.out_data), 32'h5A);
        step("t6_pop", 1'b0, 8'h00, 1'b1, 1'b0);

`ifdef ARCH_OUTPUT_BUFFER_STATS_EN
        // Drop counter saturation and clear.
        for (int i = 0; i < DEPTH; i++) step("st_fill", 1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step("st_drop", 1'b1, 8'hEE, 1'b0, 1'b0);
        check("st_drop_sat", 32'(bus.drop_count), 32'hFF);
        step("st_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        check("st_drop_clr", 32'(bus.drop_count), 32'd0);
        for (int i = 0; i < DEPTH; i++) step("st_drain", 1'b0, 8'h00, 1'b1, 1'b0);
`endif

        // Randomized traffic: stall-heavy phase, balanced phase, drain-heavy phase.
        for (int i = 0; i < 900; i++) begin
            logic en, rdy, clr;
            int ready_pct;
            ready_pct = (i < 300) ? 25 : ((i < 600) ? 50 : 80);
            en  = ($urandom_range(0, 99) < 70);
            rdy = ($urandom_range(0, 99) < ready_pct);
            clr = ($urandom_range(0, 15) == 0);
            step("rnd", en, 8'($urandom), rdy, clr);
        end
        while (q.size() != 0) step("rnd_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
